// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative signed/unsigned multiply/divide unit with start/busy/done handshake
// Optional feature macro: MDU_FAST_MUL_EN (multiplies computed in one pass, skipping RUN).
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

`ifdef MDU_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
`else
    localparam logic FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             inv_q;
    logic             neg_q;
    logic             rneg_q;
    logic             dz_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] araw_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             op_valid;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign op_valid  = (m[2:1] == 2'b00);
    assign op_signed = ~m[3];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One shift-add multiply step: multiplier bits are consumed from acc_lo_q[0].
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);

    // One restoring divide step: dividend bits shift from acc_lo_q into the remainder.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
`ifdef MDU_FAST_MUL_EN
    assign prod = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
`else
    assign prod = {acc_hi_q, acc_lo_q};
`endif
    assign prod_s = neg_q ? -prod : prod;

    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        hi_d = '0;
        lo_d = '0;
        if (inv_q) begin
            hi_d = '0;
            lo_d = '0;
        end else if (!div_q) begin
            {hi_d, lo_d} = prod_s;
        end else if (dz_q) begin
            // Magnitude-based division cannot reproduce the raw dividend, so keep it aside.
            hi_d = araw_q;
            lo_d = '1;
        end else begin
            lo_d = neg_q ? -acc_lo_q : acc_lo_q;
            hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            inv_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            araw_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q   <= 1'b1;
                        div_q    <= m[0];
                        inv_q    <= ~op_valid;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        dz_q     <= (b == '0);
                        opa_q    <= a_mag;
                        opb_q    <= b_mag;
                        araw_q   <= a;
                        acc_hi_q <= '0;
                        acc_lo_q <= m[0] ? a_mag : b_mag;
                        cnt_q    <= CW'(WIDTH - 1);
                        state_q  <= (!op_valid || (FAST_MUL && !m[0])) ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        if (div_q) begin
                            acc_hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi_q <= mul_sum[WIDTH:1];
                            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (!cancel) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - randomized and directed checks of mdu_seq against an arithmetic reference model
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .m      (m),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mdu(input logic [3:0] mm, input logic [31:0] aa, input logic [31:0] bb);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     res;
        sa  = longint'($signed(aa));
        sb  = longint'($signed(bb));
        ua  = {32'h0, aa};
        ub  = {32'h0, bb};
        res = 64'h0;
        case (mm)
            4'b0000: res = sa * sb;
            4'b1000: res = ua * ub;
            4'b0001, 4'b1001: begin
                if (bb == 32'h0) begin
                    res = {aa, 32'hFFFF_FFFF};
                end else if (mm == 4'b0001 && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                    res = {32'h0, aa};
                end else if (mm == 4'b0001) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    q   = longint'(ua / ub);
                    r   = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    function automatic int exp_lat(input logic [3:0] mm);
        if (mm[2:1] != 2'b00) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!mm[0]) return 1;
`endif
        return W + 1;
    endfunction

    task automatic launch(input logic [3:0] mm, input logic [31:0] aa, input logic [31:0] bb, input logic cx);
        start  = 1'b1;
        cancel = cx;
        m      = mm;
        a      = aa;
        b      = bb;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 200);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic run_check(input string tag, input logic [3:0] mm, input logic [31:0] aa,
                             input logic [31:0] bb, input logic cx);
        int cyc;
        launch(mm, aa, bb, cx);
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        check({tag, "_lat"}, cyc, exp_lat(mm));
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_res"}, {hi, lo}, ref_mdu(mm, aa, bb));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [3:0]  codes [4];
        logic [3:0]  mm;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [63:0] prev;
        int          cyc;

        codes  = '{4'b0000, 4'b0001, 4'b1000, 4'b1001};
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        m      = 4'h0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hilo", {hi, lo}, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_check("smul", 4'b0000, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_check("sdiv", 4'b0001, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_check("udiv", 4'b1001, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_check("div0", 4'b0001, 32'h1234_5678, 32'h0, 1'b0);
        run_check("udiv0", 4'b1001, 32'h8765_4321, 32'h0, 1'b0);
        run_check("sovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_check("umul", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_check("inval", 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_check("start_beats_cancel", 4'b0001, 32'd100, 32'hFFFF_FFF9, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) mm = 4'($urandom_range(0, 15));
            else mm = codes[$urandom_range(0, 3)];
            aa = pick_opnd();
            bb = pick_opnd();
            run_check("rand", mm, aa, bb, 1'b0);
        end

        // start held through busy with changing operands, then accepted again in the done cycle
        start = 1'b1;
        m     = 4'b0001;
        a     = 32'd1000;
        b     = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        m = 4'b1001;
        a = 32'd999;
        b = 32'd10;
        wait_done(cyc);
        check("hold_lat", cyc, W + 1);
        check("hold_res", {hi, lo}, ref_mdu(4'b0001, 32'd1000, 32'hFFFF_FFFD));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(cyc);
        check("b2b_lat", cyc, W + 1);
        check("b2b_res", {hi, lo}, ref_mdu(4'b1001, 32'd999, 32'd10));
        @(posedge clk);
        #1;

        prev = {hi, lo};
        launch(4'b0001, 32'd12345, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_run_busy", busy, 0);
        check("cancel_run_done", done, 0);
        check("cancel_run_hilo", {hi, lo}, prev);
        watch_no_done("cancel_run_nodone", W + 5);

        launch(4'b1001, 32'd54321, 32'd9, 1'b0);
        repeat (W) @(posedge clk);
        #1;
        check("fix_busy", busy, 1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_fix_busy", busy, 0);
        check("cancel_fix_done", done, 0);
        check("cancel_fix_hilo", {hi, lo}, prev);
        watch_no_done("cancel_fix_nodone", 5);

        run_check("after_cancel", 4'b0000, 32'h0001_2345, 32'hFFFF_0000, 1'b0);

        launch(4'b0001, 32'd77777, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        watch_no_done("rst_mid_nodone", W + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
